level_controller: RTL and testbench

- Game-flow sequencer that sits directly downstream of the judging stage.
- Consumes the one-cycle incLevel / lose verdict pulses and maintains the current level and remaining lives.
- Sequences the show / answer / result phases for the symbol display and input stages, and flags game-over or game-won.

---
 rtl/game_pkg.sv | 16 +
 rtl/phase_timer.sv | 27 ++
 rtl/level_controller.sv | 144 ++++++++++++++
 tb/tb_level_controller.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Types and widths shared by the game-flow sequencer and its phase timer.
package game_pkg;

   localparam int LEVEL_W = 4;
   localparam int LIVES_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      SHOW,
      ANSWER,
      RESULT,
      OVER,
      WON
   } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the SHOW and RESULT phases.
// It stops at zero and flags done while the count is zero.
module phase_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_loadValue,
   output logic             o_done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/level_controller.sv
// Game-flow sequencer: turns judge verdicts into level/lives bookkeeping
// and drives the show / answer / result phases.
module level_controller
   import game_pkg::*;
#(
   parameter int MAX_LEVEL     = 15,
   parameter int LIVES         = 3,
   parameter int SHOW_CYCLES   = 100_000_000,
   parameter int RESULT_CYCLES = 50_000_000
) (
   input  logic               Clk100M,
   input  logic               Reset_n,
   input  logic               start,
   input  logic               incLevel,
   input  logic               lose,
   output logic [LEVEL_W-1:0] level,
   output logic [1:0]         lives,
   output logic               levelStart,
   output logic               showSymbols,
   output logic               inputEnable,
   output logic               resultPass,
   output logic               resultFail,
   output logic               gameOver,
   output logic               gameWon
);

   localparam int MAX_CYCLES = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
   localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [TIMER_W-1:0] SHOW_LOAD   = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RESULT_LOAD = TIMER_W'(RESULT_CYCLES - 1);
   localparam logic [LEVEL_W-1:0] MAX_LVL     = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] FIRST_LVL   = LEVEL_W'(1);
   localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);

   state_t             r_state;
   logic [LEVEL_W-1:0] r_level;
   logic [LIVES_W-1:0] r_lives;
   logic               r_pass;
   logic               r_levelStart;

   state_t             w_nextState;
   logic [LEVEL_W-1:0] w_nextLevel;
   logic [LIVES_W-1:0] w_nextLives;
   logic               w_nextPass;
   logic               w_load;
   logic [TIMER_W-1:0] w_loadValue;
   logic               w_done;

   phase_timer #(
      .WIDTH (TIMER_W)
   ) u_phaseTimer (
      .clk         (Clk100M),
      .rst_n       (Reset_n),
      .i_load      (w_load),
      .i_loadValue (w_loadValue),
      .o_done      (w_done)
   );

   always_ff @(posedge Clk100M or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= IDLE;
         r_level      <= FIRST_LVL;
         r_lives      <= LIVES_INIT;
         r_pass       <= 1'b0;
         r_levelStart <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_level      <= w_nextLevel;
         r_lives      <= w_nextLives;
         r_pass       <= w_nextPass;
         r_levelStart <= (w_nextState == SHOW) && (r_state != SHOW);
      end
   end

   // Every phase entry reloads the shared timer on the same edge as the state change.
   always_comb begin
      w_nextState = r_state;
      w_nextLevel = r_level;
      w_nextLives = r_lives;
      w_nextPass  = r_pass;
      w_load      = 1'b0;
      w_loadValue = SHOW_LOAD;
      case (r_state)
         IDLE, OVER, WON: begin
            if (start) begin
               w_nextLevel = FIRST_LVL;
               w_nextLives = LIVES_INIT;
               w_nextState = SHOW;
               w_load      = 1'b1;
            end
         end
         SHOW: begin
            if (w_done) begin
               w_nextState = ANSWER;
            end
         end
         ANSWER: begin
            if (lose) begin
               if (r_lives == LIVES_W'(1)) begin
                  w_nextLives = '0;
                  w_nextState = OVER;
               end else begin
                  w_nextLives = r_lives - LIVES_W'(1);
                  w_nextPass  = 1'b0;
                  w_nextState = RESULT;
                  w_load      = 1'b1;
                  w_loadValue = RESULT_LOAD;
               end
            end else if (incLevel) begin
               if (r_level == MAX_LVL) begin
                  w_nextState = WON;
               end else begin
                  w_nextLevel = r_level + LEVEL_W'(1);
                  w_nextPass  = 1'b1;
                  w_nextState = RESULT;
                  w_load      = 1'b1;
                  w_loadValue = RESULT_LOAD;
               end
            end
         end
         RESULT: begin
            if (w_done) begin
               w_nextState = SHOW;
               w_load      = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign level       = r_level;
   assign lives       = r_lives;
   assign levelStart  = r_levelStart;
   assign showSymbols = (r_state == SHOW);
   assign inputEnable = (r_state == ANSWER);
   assign resultPass  = (r_state == RESULT) && r_pass;
   assign resultFail  = (r_state == RESULT) && !r_pass;
   assign gameOver    = (r_state == OVER);
   assign gameWon     = (r_state == WON);

endmodule

// File: tb/tb_level_controller.sv
// Self-checking bench for level_controller: a phase/countdown model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_level_controller;

   localparam int SC = 8;
   localparam int RC = 4;
   localparam int ML = 3;
   localparam int LV = 2;

   localparam int P_IDLE   = 0;
   localparam int P_SHOW   = 1;
   localparam int P_ANSWER = 2;
   localparam int P_RESULT = 3;
   localparam int P_OVER   = 4;
   localparam int P_WON    = 5;

   logic       Clk100M;
   logic       Reset_n;
   logic       start;
   logic       incLevel;
   logic       lose;
   logic [3:0] level;
   logic [1:0] lives;
   logic       levelStart;
   logic       showSymbols;
   logic       inputEnable;
   logic       resultPass;
   logic       resultFail;
   logic       gameOver;
   logic       gameWon;

   int total = 0;
   int bad = 0;
   bit checkEn = 1'b0;

   int mPhase = P_IDLE;
   int mLeft = 0;
   int mLevel = 1;
   int mLives = LV;
   bit mPass = 1'b0;
   bit mFirst = 1'b0;

   level_controller #(
      .MAX_LEVEL     (ML),
      .LIVES         (LV),
      .SHOW_CYCLES   (SC),
      .RESULT_CYCLES (RC)
   ) dut (
      .Clk100M     (Clk100M),
      .Reset_n     (Reset_n),
      .start       (start),
      .incLevel    (incLevel),
      .lose        (lose),
      .level       (level),
      .lives       (lives),
      .levelStart  (levelStart),
      .showSymbols (showSymbols),
      .inputEnable (inputEnable),
      .resultPass  (resultPass),
      .resultFail  (resultFail),
      .gameOver    (gameOver),
      .gameWon     (gameWon)
   );

   initial begin
      Clk100M = 1'b0;
      forever #5 Clk100M = ~Clk100M;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total = total + 1;
      if (actual != expected) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: each phase is a countdown of cycles left; game rules applied per sampled verdict.
   always @(posedge Clk100M or negedge Reset_n) begin
      if (!Reset_n) begin
         mPhase <= P_IDLE;
         mLeft  <= 0;
         mLevel <= 1;
         mLives <= LV;
         mPass  <= 1'b0;
         mFirst <= 1'b0;
      end else begin
         mFirst <= 1'b0;
         case (mPhase)
            P_SHOW: begin
               if (mLeft == 1) mPhase <= P_ANSWER;
               else mLeft <= mLeft - 1;
            end
            P_ANSWER: begin
               if (lose) begin
                  if (mLives == 1) begin
                     mLives <= 0;
                     mPhase <= P_OVER;
                  end else begin
                     mLives <= mLives - 1;
                     mPass  <= 1'b0;
                     mPhase <= P_RESULT;
                     mLeft  <= RC;
                  end
               end else if (incLevel) begin
                  if (mLevel == ML) begin
                     mPhase <= P_WON;
                  end else begin
                     mLevel <= mLevel + 1;
                     mPass  <= 1'b1;
                     mPhase <= P_RESULT;
                     mLeft  <= RC;
                  end
               end
            end
            P_RESULT: begin
               if (mLeft == 1) begin
                  mPhase <= P_SHOW;
                  mLeft  <= SC;
                  mFirst <= 1'b1;
               end else begin
                  mLeft <= mLeft - 1;
               end
            end
            default: begin
               if (start) begin
                  mLevel <= 1;
                  mLives <= LV;
                  mPhase <= P_SHOW;
                  mLeft  <= SC;
                  mFirst <= 1'b1;
               end
            end
         endcase
      end
   end

   // Compare DUT against the model in the middle of every clock period.
   always @(negedge Clk100M) begin
      if (checkEn) begin
         checkOutput("cmp.level", int'(level), mLevel);
         checkOutput("cmp.lives", int'(lives), mLives);
         checkOutput("cmp.levelStart", int'(levelStart), int'(mPhase == P_SHOW && mFirst));
         checkOutput("cmp.showSymbols", int'(showSymbols), int'(mPhase == P_SHOW));
         checkOutput("cmp.inputEnable", int'(inputEnable), int'(mPhase == P_ANSWER));
         checkOutput("cmp.resultPass", int'(resultPass), int'(mPhase == P_RESULT && mPass));
         checkOutput("cmp.resultFail", int'(resultFail), int'(mPhase == P_RESULT && !mPass));
         checkOutput("cmp.gameOver", int'(gameOver), int'(mPhase == P_OVER));
         checkOutput("cmp.gameWon", int'(gameWon), int'(mPhase == P_WON));
      end
   end

   task automatic applyStimulus(input bit s, input bit inc, input bit l);
      @(negedge Clk100M);
      #1;
      start    = s;
      incLevel = inc;
      lose     = l;
      @(negedge Clk100M);
      #1;
      start    = 1'b0;
      incLevel = 1'b0;
      lose     = 1'b0;
   endtask

   task automatic waitInputEnable();
      for (int i = 0; i < 40 && !inputEnable; i++) begin
         @(negedge Clk100M);
         #1;
      end
      checkOutput("wait.inputEnable", int'(inputEnable), 1);
   endtask

   task automatic waitShowSymbols();
      for (int i = 0; i < 40 && !showSymbols; i++) begin
         @(negedge Clk100M);
         #1;
      end
      checkOutput("wait.showSymbols", int'(showSymbols), 1);
   endtask

   task automatic checkAllLow(input string tag);
      checkOutput({tag, ".flags"},
                  int'({levelStart, showSymbols, inputEnable, resultPass,
                        resultFail, gameOver, gameWon}), 0);
      checkOutput({tag, ".level"}, int'(level), 1);
      checkOutput({tag, ".lives"}, int'(lives), 2);
   endtask

   initial begin
      int cnt;
      Reset_n  = 1'b0;
      start    = 1'b0;
      incLevel = 1'b0;
      lose     = 1'b0;
      repeat (2) @(posedge Clk100M);
      checkEn = 1'b1;
      @(negedge Clk100M);
      #1;
      checkAllLow("reset");
      Reset_n = 1'b1;

      // Scenario 1: start, eight show cycles, then answer at level 1.
      applyStimulus(1, 0, 0);
      checkOutput("s1.levelStart", int'(levelStart), 1);
      cnt = 0;
      while (showSymbols && cnt < 20) begin
         cnt++;
         @(negedge Clk100M);
         #1;
      end
      checkOutput("s1.showLength", cnt, 8);
      checkOutput("s1.inputEnable", int'(inputEnable), 1);
      checkOutput("s1.level", int'(level), 1);
      checkOutput("s1.lives", int'(lives), 2);

      // Scenario 2: pass to level 2, four result cycles, new show.
      applyStimulus(0, 1, 0);
      checkOutput("s2.level", int'(level), 2);
      cnt = 0;
      while (resultPass && cnt < 20) begin
         cnt++;
         @(negedge Clk100M);
         #1;
      end
      checkOutput("s2.resultLength", cnt, 4);
      checkOutput("s2.levelStart", int'(levelStart), 1);
      waitInputEnable();

      // Scenario 3: fail keeps level 2, last life ends the game without a result phase.
      applyStimulus(0, 0, 1);
      checkOutput("s3.lives", int'(lives), 1);
      checkOutput("s3.level", int'(level), 2);
      cnt = 0;
      while (resultFail && cnt < 20) begin
         cnt++;
         @(negedge Clk100M);
         #1;
      end
      checkOutput("s3.resultLength", cnt, 4);
      waitInputEnable();
      checkOutput("s3.replayLevel", int'(level), 2);
      applyStimulus(0, 0, 1);
      checkOutput("s3.gameOver", int'(gameOver), 1);
      checkOutput("s3.noResult", int'(resultFail), 0);
      checkOutput("s3.livesZero", int'(lives), 0);

      // Scenario 4: restart and climb to the top level, then win.
      applyStimulus(1, 0, 0);
      checkOutput("s4.restartLevel", int'(level), 1);
      checkOutput("s4.restartLives", int'(lives), 2);
      waitInputEnable();
      applyStimulus(0, 1, 0);
      waitInputEnable();
      applyStimulus(0, 1, 0);
      waitInputEnable();
      checkOutput("s4.topLevel", int'(level), 3);
      applyStimulus(0, 1, 0);
      checkOutput("s4.gameWon", int'(gameWon), 1);
      checkOutput("s4.wonLevel", int'(level), 3);
      applyStimulus(1, 0, 0);
      checkOutput("s4.newGameLevel", int'(level), 1);
      checkOutput("s4.newGameShow", int'(showSymbols), 1);

      // Scenario 5: stray pulses are dropped; simultaneous verdicts count as lose.
      applyStimulus(0, 1, 1);
      checkOutput("s5.showIgnored", int'(showSymbols), 1);
      waitInputEnable();
      checkOutput("s5.levelAfterShow", int'(level), 1);
      checkOutput("s5.livesAfterShow", int'(lives), 2);
      applyStimulus(1, 0, 0);
      checkOutput("s5.startIgnored", int'(inputEnable), 1);
      applyStimulus(0, 1, 1);
      checkOutput("s5.bothIsLose", int'(resultFail), 1);
      checkOutput("s5.bothLives", int'(lives), 1);
      applyStimulus(0, 1, 0);
      checkOutput("s5.resultIgnored", int'(resultFail), 1);
      checkOutput("s5.resultLevel", int'(level), 1);
      waitInputEnable();
      checkOutput("s5.livesKept", int'(lives), 1);

      // Scenario 6: asynchronous reset mid-SHOW and mid-RESULT.
      applyStimulus(0, 1, 0);
      waitShowSymbols();
      @(negedge Clk100M);
      #1;
      Reset_n = 1'b0;
      #1;
      checkAllLow("s6.showReset");
      repeat (2) @(negedge Clk100M);
      #1;
      Reset_n = 1'b1;
      applyStimulus(1, 0, 0);
      checkOutput("s6.resumeStart", int'(levelStart), 1);
      waitInputEnable();
      applyStimulus(0, 1, 0);
      checkOutput("s6.inResult", int'(resultPass), 1);
      Reset_n = 1'b0;
      #1;
      checkAllLow("s6.resultReset");
      repeat (2) @(negedge Clk100M);
      #1;
      Reset_n = 1'b1;
      applyStimulus(1, 0, 0);
      checkOutput("s6.resumeShow", int'(showSymbols), 1);
      checkOutput("s6.resumeLevel", int'(level), 1);
      waitInputEnable();

      @(negedge Clk100M);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
